// File: rtl/alu_pkg.sv
// Shared codes, state encoding and helpers for the ALU op sequencer.
// ALU_SELFCHECK_EN adds the behavioural ALU model used for the self-check.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ILL   = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETTLE = 2'b01,
        RESP   = 2'b10
    } state_t;

`ifdef ALU_SELFCHECK_EN
    // Reference result of the ALU for a latched op.
    function automatic logic [31:0] alu_model(
        input logic [2:0]  sig,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] r;
        case (sig)
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_SLT: r = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
            default: r = 32'h0;
        endcase
        return r;
    endfunction
`endif

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational decode of (aluop, funct) into the 3-bit ALU signal.
// Unsupported aluop/funct combinations raise illegal with signal 000.
module alu_funct_decode
    import alu_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] signal,
    output logic       illegal
);

    // Map the request encoding onto the ALU control code.
    always_comb begin
        signal  = ALU_AND;
        illegal = 1'b0;
        case (aluop)
            ALUOP_ADD: signal = ALU_ADD;
            ALUOP_SUB: signal = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: signal = ALU_ADD;
                    FUNCT_SUB: signal = ALU_SUB;
                    FUNCT_AND: signal = ALU_AND;
                    FUNCT_OR:  signal = ALU_OR;
                    FUNCT_SLT: signal = ALU_SLT;
                    default:   illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues ops to a ripple ALU, holds operands for a settle window, captures.
// ALU_SELFCHECK_EN adds rsp_mismatch, comparing alu_out with a model.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_aluop,
    input  logic [5:0]        req_funct,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_signal,
    input  logic [DATA_W-1:0] alu_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
`ifdef ALU_SELFCHECK_EN
    output logic              rsp_mismatch,
`endif
    output logic              rsp_err
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [2:0]        r_alu_sig;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;
    logic              r_err;
    logic [2:0]        w_dec_sig;
    logic              w_dec_ill;
    logic              w_accept;
    logic              w_capture;

    alu_funct_decode u_dec (
        .aluop   (req_aluop),
        .funct   (req_funct),
        .signal  (w_dec_sig),
        .illegal (w_dec_ill)
    );

    assign w_accept  = (r_state == IDLE) && req_valid;
    assign w_capture = (r_state == SETTLE) && (r_cnt == '0);

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; illegal requests skip the settle window.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid)
                    w_next = w_dec_ill ? RESP : SETTLE;
            end
            SETTLE: begin
                if (r_cnt == '0) w_next = RESP;
            end
            RESP: begin
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Handshake outputs derived from the registered state.
    always_comb begin
        req_ready = (r_state == IDLE) && rst_n;
        rsp_valid = (r_state == RESP);
    end

    // Operand latch, settle counter and response capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sig <= ALU_AND;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            if (w_dec_ill) begin
                r_result <= '0;
                r_zero   <= 1'b0;
                r_err    <= 1'b1;
            end else begin
                r_alu_a   <= req_a;
                r_alu_b   <= req_b;
                r_alu_sig <= w_dec_sig;
                r_cnt     <= CNT_LOAD;
            end
        end else if (w_capture) begin
            r_result <= alu_out;
            r_zero   <= (alu_out == '0);
            r_err    <= 1'b0;
        end else if (r_state == SETTLE) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

`ifdef ALU_SELFCHECK_EN
    logic r_mismatch;

    // Compare the settled ALU output against the reference model.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_mismatch <= 1'b0;
        else if (w_accept)
            r_mismatch <= 1'b0;
        else if (w_capture)
            r_mismatch <= (alu_out !=
                alu_model(r_alu_sig, r_alu_a, r_alu_b));
    end

    assign rsp_mismatch = r_mismatch;
`endif

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_signal = r_alu_sig;
    assign rsp_result = r_result;
    assign rsp_zero   = r_zero;
    assign rsp_err    = r_err;

endmodule
